program_loader: RTL
===================

Name: program_loader

Overview:
- Write-side counterpart to the core's instruction fetch path. The PC/decoder only ever read program memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles it into INS_WIDTH-bit instructions.
- Writes each instruction into program memory, starting at address 0.
- Holds the processor core in reset until a load completes successfully.

Parameters:
- ADDR_WIDTH, 6: program memory address width; depth = 2**ADDR_WIDTH.
- INS_WIDTH, 13: instruction width. Legal range 9..16, so each instruction is exactly 2 bytes.

Ports:
- clk, input, 1: clock, rising edge.
- nReset, input, 1: synchronous active-low reset.
- Start, input, 1: single-cycle request to begin a load.
- ByteIn, input, 8: stream byte.
- ByteValid, input, 1: ByteIn is valid.
- ByteReady, output, 1: loader accepts ByteIn this cycle.
- PM_WE, output, 1: program memory write enable, one-cycle pulse.
- PM_WAddr, output, ADDR_WIDTH: write address.
- PM_WData, output, INS_WIDTH: write data.
- CoreNReset, output, 1: active-low reset to the PC, register file, accumulator and data memory.
- Busy, output, 1: load in progress.
- Done, output, 1: last load succeeded; sticky.
- Error, output, 1: last load failed; sticky.

Behaviour:
- Reset (nReset=0 at a clk edge):
  - State=IDLE.
  - All outputs 0, including CoreNReset=0 (core held in reset), PM_WAddr=0, PM_WData=0.
  - Count and checksum registers cleared.
- Reset mid-load aborts the load immediately. Words already written stay in memory.
- Handshake: a byte transfers on a clk edge where ByteValid=1 and ByteReady=1. ByteReady=1 only in LEN, HI, LO and CSUM.
- States:
  - IDLE: Start=1 -> LEN; Busy=1, Done=0, Error=0, CoreNReset=0, address counter=0, checksum=0.
  - LEN: accept byte N = instruction count.
    - N=0 or N>2**ADDR_WIDTH -> ERR.
    - Otherwise latch N -> HI.
  - HI: accept byte, bits [INS_WIDTH-9:0] = instruction [INS_WIDTH-1:8].
    - Any nonzero bit above INS_WIDTH-9 -> ERR.
    - Otherwise -> LO.
  - LO: accept byte = instruction [7:0] -> WR.
  - WR: PM_WE=1 for exactly this cycle, with PM_WAddr and PM_WData stable. ByteReady=0.
    - Next cycle: address counter +1.
    - If words written == N -> CSUM (or DONE, see Optional Feature).
    - Else -> HI.
- Address arithmetic: the address counter is ADDR_WIDTH+1 bits wide, so N=64 terminates without wrapping. PM_WAddr = its low ADDR_WIDTH bits.
- Checksum: 8-bit sum modulo 256 of every HI and LO byte accepted. The LEN byte is excluded.
  - CSUM: accept byte; equal to checksum -> DONE, else -> ERR.
- DONE: Busy=0, Done=1, CoreNReset=1 from the cycle after entry. ByteReady=0.
- ERR: Busy=0, Error=1, CoreNReset=0. ByteReady=0.
- Start in DONE or ERR -> LEN:
  - CoreNReset drops to 0 in the same cycle the state becomes LEN.
  - Done and Error clear.
- Start while Busy is ignored.
- ByteValid while ByteReady=0 is not consumed. The source must hold the byte.
- A gap (ByteValid=0) in any accepting state leaves the state unchanged. There is no timeout.
- Write latency: PM_WE asserts exactly 1 cycle after the LO byte transfer.
- Minimum load duration: 1 + 3N + 1 cycles, with ByteValid held high and LOADER_CHECKSUM_EN defined.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: CSUM state present as above.
- Undefined:
  - No checksum byte is expected; WR goes straight to DONE after the Nth word.
  - The checksum register is removed.
  - The ERR causes are limited to a bad N or bad HI bits.

Test Plan:
- Reset then Start; stream 0x02, 0x01,0x23, 0x1F,0xFF, csum 0x42 with ByteValid held high:
  - Writes at addr0=0x0123 and addr1=0x1FFF, each a single-cycle PM_WE.
  - Then Done=1, CoreNReset=1.
- Same stream with csum 0x41 -> Error=1, CoreNReset=0, Done=0. Both words are still written.
- N=0x00 -> ERR after 1 byte, no PM_WE. N=0x41 -> ERR. N=0x40 with 128 bytes plus a correct csum -> addresses 0..63 written once each, no wrap, Done=1.
- HI byte 0x20 (bit 5 set) -> ERR on that byte, no PM_WE for that word.
- Handshake stress:
  - Random ByteValid gaps across a 3-word load -> identical writes and final state.
  - ByteValid during WR -> byte is not consumed.
- Reset mid-load (after 1 word), then Start and a 1-word load -> state returns to IDLE with CoreNReset=0; the new load writes addr0 and reaches Done. With the macro undefined, the csum byte is omitted and Done follows the last write.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: fills program memory from a byte stream and holds the core
// in reset until a load completes successfully.
//
// Stream format: one length byte N (1..2**ADDR_WIDTH), then N instructions
// as {HI, LO} byte pairs, then (when LOADER_CHECKSUM_EN is defined) one byte
// equal to the modulo-256 sum of every HI and LO byte. Instruction i is
// written to address i.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   - trailing checksum byte is expected and verified.
//   undefined - no checksum byte; the load completes after the Nth write.
//
// Ports:
//   clk        - clock, rising edge
//   nReset     - synchronous active-low reset
//   Start      - single-cycle load request (ignored while Busy)
//   ByteIn     - stream byte
//   ByteValid  - ByteIn valid
//   ByteReady  - loader accepts ByteIn this cycle
//   PM_WE      - program memory write enable (one-cycle pulse)
//   PM_WAddr   - program memory write address
//   PM_WData   - program memory write data
//   CoreNReset - active-low reset to the core; released only after success
//   Busy       - load in progress
//   Done       - last load succeeded (sticky)
//   Error      - last load failed (sticky)

module program_loader #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned INS_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  Start,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  PM_WE,
  output logic [ADDR_WIDTH-1:0] PM_WAddr,
  output logic [INS_WIDTH-1:0]  PM_WData,
  output logic                  CoreNReset,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  // One extra counter bit so a full-depth load terminates without wrapping.
  localparam int unsigned CntW   = ADDR_WIDTH + 1;
  localparam int unsigned HiBits = INS_WIDTH - 8;
  localparam logic [31:0] Depth  = 32'(1) << ADDR_WIDTH;
  // HI-byte bits that lie above the instruction width and must be zero.
  localparam logic [7:0]  HiBadMask = 8'(32'hFF << HiBits);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StHi,
    StLo,
    StWr,
    StCsum,
    StDone,
    StErr
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [CntW-1:0]       len_q, len_d;
  logic [INS_WIDTH-1:0]  data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  core_nrst_q, core_nrst_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic xfer;
  logic len_ok;
  logic hi_bad;

  assign xfer   = ByteValid & ready_q;
  assign len_ok = (ByteIn != 8'd0) && (32'(ByteIn) <= Depth);
  assign hi_bad = |(ByteIn & HiBadMask);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (Start) begin
          state_d = StLen;
          cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      StLen: begin
        if (xfer) begin
          if (len_ok) begin
            len_d   = CntW'(ByteIn);
            state_d = StHi;
          end else begin
            state_d = StErr;
          end
        end
      end

      StHi: begin
        if (xfer) begin
          data_d[INS_WIDTH-1:8] = ByteIn[HiBits-1:0];
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + ByteIn;
`endif
          state_d = hi_bad ? StErr : StLo;
        end
      end

      StLo: begin
        if (xfer) begin
          data_d[7:0] = ByteIn;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + ByteIn;
`endif
          state_d = StWr;
        end
      end

      StWr: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_d == len_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StHi;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      StCsum: begin
        if (xfer) begin
          state_d = (ByteIn == csum_q) ? StDone : StErr;
        end
      end
`endif

      default: state_d = StIdle;
    endcase

    // Outputs are registered from the state being entered so they line up
    // with the state register in the same cycle.
    ready_d     = (state_d == StLen) || (state_d == StHi) ||
                  (state_d == StLo)  || (state_d == StCsum);
    we_d        = (state_d == StWr);
    busy_d      = ready_d || (state_d == StWr);
    done_d      = (state_d == StDone);
    error_d     = (state_d == StErr);
    core_nrst_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      core_nrst_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      core_nrst_q <= core_nrst_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign ByteReady  = ready_q;
  assign PM_WE      = we_q;
  assign PM_WAddr   = cnt_q[ADDR_WIDTH-1:0];
  assign PM_WData   = data_q;
  assign CoreNReset = core_nrst_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Error      = error_q;

endmodule
